load_unit_ctrl_rv32: RTL and testbench

//  Sequences one RV32 load at a time between the execute stage and the data-memory port.
//  - Takes a load request and checks alignment.
//  - Issues a word-aligned memory read with a valid/ready handshake.
//  - Waits for the response, with a timeout watchdog.
//  - Shifts the addressed byte/half into the low bits, then sign- or zero-extends it.
//  - Presents the result to writeback on a valid/ready handshake.

---
 rtl/load_unit_ctrl_rv32.sv | 220 ++++++++++++++++++++++
 tb/tb_load_unit_ctrl_rv32.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit_ctrl_rv32.sv
// -----------------------------------------------------------------------------
// load_unit_ctrl_rv32
//
// Handles one RV32 load at a time between the execute stage and the
// data-memory read port. It accepts a load, checks alignment, issues a
// word-aligned read, waits for the response under a timeout watchdog,
// formats the addressed byte/half/word with sign or zero extension, and then
// hands the result to writeback.
//
// Parameters
//   DATA_LEN     data/address width (only 32 is supported)
//   TIMEOUT_CYC  WAIT cycles without a response before an access fault (1..65535)
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   ld_valid/ld_ready   load request handshake from execute
//   ld_addr             byte address of the load
//   ld_funct3           000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   ld_rd               destination register, returned on wb_rd
//   mem_req_valid/ready memory read request handshake
//   mem_req_addr        word-aligned request address
//   mem_resp_valid      single-cycle read-data strobe
//   mem_resp_data       aligned 32-bit read word
//   mem_resp_err        bus error, qualified by mem_resp_valid
//   wb_valid/wb_ready   writeback handshake
//   wb_data             extended load data (0 when wb_exc=1)
//   wb_rd               captured destination register
//   wb_exc, wb_cause    exception flag and cause (4 misaligned, 5 access fault)
// -----------------------------------------------------------------------------
module load_unit_ctrl_rv32 #(
   parameter int DATA_LEN    = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [DATA_LEN-1:0] ld_addr,
   input  logic [2:0]          ld_funct3,
   input  logic [4:0]          ld_rd,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [DATA_LEN-1:0] mem_req_addr,
   input  logic                mem_resp_valid,
   input  logic [DATA_LEN-1:0] mem_resp_data,
   input  logic                mem_resp_err,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [DATA_LEN-1:0] wb_data,
   output logic [4:0]          wb_rd,
   output logic                wb_exc,
   output logic [3:0]          wb_cause
);

   localparam logic [3:0]  CAUSE_MISALIGN = 4'd4;
   localparam logic [3:0]  CAUSE_FAULT    = 4'd5;
   localparam logic [16:0] TMO_LIMIT      = 17'(TIMEOUT_CYC);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state, state_nxt;
   logic [DATA_LEN-1:0] addr_q, addr_nxt;
   logic [2:0]          f3_q, f3_nxt;
   logic [4:0]          rd_q, rd_nxt;
   logic [DATA_LEN-1:0] data_q, data_nxt;
   logic                exc_q, exc_nxt;
   logic [3:0]          cause_q, cause_nxt;
   logic [15:0]         cnt_q, cnt_nxt;

   logic [16:0]         cnt_inc;
   logic                misaligned;
   logic [DATA_LEN-1:0] shifted;
   logic [DATA_LEN-1:0] formatted;

   // Alignment check on the incoming request; illegal funct3 codes are
   // never misaligned and still go out to memory.
   always_comb begin
      misaligned = 1'b0;
      case (ld_funct3)
         F3_LH, F3_LHU: misaligned = ld_addr[0];
         F3_LW:         misaligned = |ld_addr[1:0];
         default:       misaligned = 1'b0;
      endcase
   end

   // Move the addressed byte lane down to bit 0, then extend by funct3.
   always_comb begin
      shifted   = mem_resp_data >> {addr_q[1:0], 3'b000};
      formatted = '0;
      case (f3_q)
         F3_LB:   formatted = {{(DATA_LEN-8){shifted[7]}}, shifted[7:0]};
         F3_LH:   formatted = {{(DATA_LEN-16){shifted[15]}}, shifted[15:0]};
         F3_LW:   formatted = shifted;
         F3_LBU:  formatted = {{(DATA_LEN-8){1'b0}}, shifted[7:0]};
         F3_LHU:  formatted = {{(DATA_LEN-16){1'b0}}, shifted[15:0]};
         default: formatted = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         exc_q   <= 1'b0;
         cause_q <= '0;
         cnt_q   <= '0;
      end else begin
         state   <= state_nxt;
         addr_q  <= addr_nxt;
         f3_q    <= f3_nxt;
         rd_q    <= rd_nxt;
         data_q  <= data_nxt;
         exc_q   <= exc_nxt;
         cause_q <= cause_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr_q;
      f3_nxt        = f3_q;
      rd_nxt        = rd_q;
      data_nxt      = data_q;
      exc_nxt       = exc_q;
      cause_nxt     = cause_q;
      cnt_nxt       = cnt_q;
      cnt_inc       = {1'b0, cnt_q} + 17'd1;

      ld_ready      = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      wb_valid      = 1'b0;
      wb_data       = '0;
      wb_rd         = '0;
      wb_exc        = 1'b0;
      wb_cause      = '0;

      case (state)
         S_IDLE: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               addr_nxt = ld_addr;
               f3_nxt   = ld_funct3;
               rd_nxt   = ld_rd;
               data_nxt = '0;
               if (misaligned) begin
                  exc_nxt   = 1'b1;
                  cause_nxt = CAUSE_MISALIGN;
                  state_nxt = S_RESP;
               end else begin
                  exc_nxt   = 1'b0;
                  cause_nxt = '0;
                  state_nxt = S_REQ;
               end
            end
         end

         S_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {addr_q[DATA_LEN-1:2], 2'b00};
            if (mem_req_ready) begin
               cnt_nxt   = '0;
               state_nxt = S_WAIT;
            end
         end

         S_WAIT: begin
            // A response in the same cycle as the timeout takes priority.
            if (mem_resp_valid) begin
               if (mem_resp_err) begin
                  exc_nxt   = 1'b1;
                  cause_nxt = CAUSE_FAULT;
                  data_nxt  = '0;
               end else begin
                  data_nxt  = formatted;
               end
               state_nxt = S_RESP;
            end else begin
               cnt_nxt = cnt_inc[15:0];
               // Fires on the TIMEOUT_CYC-th WAIT cycle without a response.
               if (cnt_inc >= TMO_LIMIT) begin
                  exc_nxt   = 1'b1;
                  cause_nxt = CAUSE_FAULT;
                  data_nxt  = '0;
                  state_nxt = S_RESP;
               end
            end
         end

         S_RESP: begin
            wb_valid = 1'b1;
            wb_data  = data_q;
            wb_rd    = rd_q;
            wb_exc   = exc_q;
            wb_cause = cause_q;
            if (wb_ready) begin
               state_nxt = S_IDLE;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_unit_ctrl_rv32.sv
// -----------------------------------------------------------------------------
// tb_load_unit_ctrl_rv32
//
// Directed and randomized loads against load_unit_ctrl_rv32 (TIMEOUT_CYC=8).
// Expected writeback values come from a reference function that applies the
// load rules arithmetically (byte offset, mask, sign bias).
// -----------------------------------------------------------------------------
module tb_load_unit_ctrl_rv32;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [2:0]  ld_funct3;
   logic [4:0]  ld_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_exc;
   logic [3:0]  wb_cause;

   int errors = 0;
   int checks = 0;

   load_unit_ctrl_rv32 #(.DATA_LEN(32), .TIMEOUT_CYC(TMO)) dut (
      .clk            (clk),
      .rst            (rst),
      .ld_valid       (ld_valid),
      .ld_ready       (ld_ready),
      .ld_addr        (ld_addr),
      .ld_funct3      (ld_funct3),
      .ld_rd          (ld_rd),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_data        (wb_data),
      .wb_rd          (wb_rd),
      .wb_exc         (wb_exc),
      .wb_cause       (wb_cause)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Reference: what writeback must show for a given load.
   task automatic model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                        input logic fault, output logic mis, output logic [31:0] d,
                        output logic exc, output logic [3:0] cause);
      int unsigned off, t, b, h;
      off = addr % 4;
      mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && off != 0);
      d = 0; exc = 0; cause = 0;
      if (mis) begin
         exc = 1; cause = 4;
      end else if (fault) begin
         exc = 1; cause = 5;
      end else begin
         t = data / (1 << (off * 8));
         b = t % 256;
         h = t % 65536;
         case (f3)
            3'd0: d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2: d = t;
            3'd4: d = b;
            3'd5: d = h;
            default: d = 0;
         endcase
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ld_ready"},      ld_ready, 1);
      chk({tag, ".mem_req_valid"}, mem_req_valid, 0);
      chk({tag, ".mem_req_addr"},  mem_req_addr, 0);
      chk({tag, ".wb_valid"},      wb_valid, 0);
      chk({tag, ".wb_data"},       wb_data, 0);
      chk({tag, ".wb_rd"},         wb_rd, 0);
      chk({tag, ".wb_exc"},        wb_exc, 0);
      chk({tag, ".wb_cause"},      wb_cause, 0);
   endtask

   // One complete load. Starts and ends at a sample point with the unit idle.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic err, input logic no_resp,
                          input int unsigned req_wait, input int unsigned resp_wait,
                          input int unsigned wb_wait);
      logic        mis, exc;
      logic [31:0] d;
      logic [3:0]  cause;
      logic [4:0]  rd;
      rd = 5'($urandom);
      model(f3, addr, data, err | no_resp, mis, d, exc, cause);

      chk({tag, ".ld_ready_start"}, ld_ready, 1);
      ld_valid = 1; ld_addr = addr; ld_funct3 = f3; ld_rd = rd;
      // A stray response while idle must have no effect.
      mem_resp_valid = 1; mem_resp_data = $urandom; mem_resp_err = 1'($urandom);
      tick();
      ld_valid = 0; ld_addr = $urandom; ld_funct3 = 3'($urandom); ld_rd = 5'($urandom);
      mem_resp_valid = 0;

      if (!mis) begin
         for (int unsigned i = 0; i <= req_wait; i++) begin
            chk({tag, ".req_valid"}, mem_req_valid, 1);
            chk({tag, ".req_addr"},  mem_req_addr, addr & 32'hFFFF_FFFC);
            chk({tag, ".wb_valid_req"}, wb_valid, 0);
            if (i == req_wait) mem_req_ready = 1;
            tick();
         end
         mem_req_ready = 0;
         chk({tag, ".no_req_in_wait"}, mem_req_valid, 0);
         if (no_resp) begin
            for (int unsigned i = 0; i < TMO; i++) begin
               chk({tag, ".wb_valid_wait"}, wb_valid, 0);
               tick();
            end
         end else begin
            for (int unsigned i = 0; i < resp_wait; i++) begin
               chk({tag, ".wb_valid_wait"}, wb_valid, 0);
               tick();
            end
            mem_resp_valid = 1; mem_resp_data = data; mem_resp_err = err;
            tick();
            mem_resp_valid = 0; mem_resp_data = $urandom; mem_resp_err = 0;
         end
      end else begin
         chk({tag, ".no_req_misaligned"}, mem_req_valid, 0);
      end

      for (int unsigned i = 0; i <= wb_wait; i++) begin
         chk({tag, ".wb_valid"}, wb_valid, 1);
         chk({tag, ".wb_data"},  wb_data, d);
         chk({tag, ".wb_rd"},    wb_rd, rd);
         chk({tag, ".wb_exc"},   wb_exc, exc);
         chk({tag, ".wb_cause"}, wb_cause, cause);
         chk({tag, ".ld_ready_resp"}, ld_ready, 0);
         chk({tag, ".no_req_in_resp"}, mem_req_valid, 0);
         if (i == wb_wait) begin
            wb_ready = 1;
         end else if (i == 0) begin
            // Late response while stalled in writeback must be ignored.
            mem_resp_valid = 1; mem_resp_data = $urandom; mem_resp_err = 1'($urandom);
         end
         // Offer a new load during the final cycle: it must not be taken.
         ld_valid = (i == wb_wait);
         tick();
         mem_resp_valid = 0;
      end
      wb_ready = 0;
      ld_valid = 0;
      chk({tag, ".wb_valid_after"}, wb_valid, 0);
      chk({tag, ".ld_ready_after"}, ld_ready, 1);
      chk({tag, ".no_bypass_req"},  mem_req_valid, 0);
   endtask

   initial begin
      rst = 1; ld_valid = 0; ld_addr = 0; ld_funct3 = 0; ld_rd = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
      wb_ready = 0;
      tick(); tick(); tick();
      chk_idle("reset");
      rst = 0;
      mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
      tick();
      mem_resp_valid = 0;
      chk_idle("post_reset");

      // Minimum-latency LB: wb_valid on cycle 3.
      do_load("lb",  3'b000, 32'h8000_0003, 32'h80FF_FF7F, 0, 0, 0, 0, 0);
      do_load("lhu", 3'b101, 32'h0000_1002, 32'hBEEF_1234, 0, 0, 0, 1, 0);
      do_load("lh",  3'b001, 32'h0000_1002, 32'hBEEF_1234, 0, 0, 0, 0, 1);
      do_load("lw_mis", 3'b010, 32'h0000_1001, 32'h1234_5678, 0, 0, 0, 0, 0);
      do_load("lh_mis", 3'b101, 32'h0000_2003, 32'h1234_5678, 0, 0, 0, 0, 2);
      do_load("req_stall_err", 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 1, 0, 5, 2, 0);
      do_load("timeout", 3'b100, 32'h0000_3001, 32'h0, 0, 1, 0, 0, 2);
      do_load("resp_at_limit", 3'b010, 32'h0000_5000, 32'h0BAD_F00D, 0, 0, 0, TMO - 1, 0);
      do_load("illegal_f3", 3'b011, 32'h0000_6003, 32'hFFFF_FFFF, 0, 0, 1, 1, 0);
      do_load("lbu_b1", 3'b100, 32'h0000_7001, 32'h0000_9A00, 0, 0, 0, 0, 0);
      do_load("wb_stall", 3'b010, 32'h0000_8000, 32'h1357_9BDF, 0, 0, 0, 0, 4);

      // Reset in the middle of a load while waiting for the response.
      chk("rst_load.ld_ready", ld_ready, 1);
      ld_valid = 1; ld_addr = 32'h0000_9004; ld_funct3 = 3'b010; ld_rd = 5'd7;
      tick();
      ld_valid = 0;
      chk("rst_load.req_valid", mem_req_valid, 1);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      chk("rst_load.in_wait", mem_req_valid, 0);
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk_idle("mid_reset");
      mem_resp_valid = 1; mem_resp_data = 32'h7777_7777;
      tick();
      mem_resp_valid = 0;
      chk_idle("resp_after_reset");
      do_load("recover", 3'b000, 32'h0000_A002, 32'h0042_0000, 0, 0, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         do_load("rand", 3'($urandom_range(0, 7)), a, $urandom,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                 $urandom_range(0, 3), $urandom_range(0, TMO - 1), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
